// File: rtl/sanduba_input_ctrl.sv
// Input conditioning, coin queue and request issue stage for the sandwich vending FSM.
// Optional statistics counters are enabled with `define SANDUBA_INPUT_STATS_EN.
module sanduba_input_ctrl #(
    parameter int SYNC_STAGES      = 2,
    parameter int DEBOUNCE_CYCLES  = 4,
    parameter int COIN_QUEUE_DEPTH = 3,
    parameter int BUSY_TIMEOUT     = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       raw_coin,
    input  logic       raw_green,
    input  logic       raw_atum,
    input  logic       raw_bacon,
    input  logic       raw_dev,
    input  logic       busy,
    output logic       m100,
    output logic       dev,
    output logic       r_green,
    output logic       r_atum,
    output logic       r_bacon,
    output logic       coin_reject,
    output logic       timeout_err
`ifdef SANDUBA_INPUT_STATS_EN
    ,
    output logic [7:0] coins_accepted,
    output logic [7:0] coins_rejected
`endif
);

    localparam int NIN       = 5;
    localparam int IDX_COIN  = 0;
    localparam int IDX_DEV   = 1;
    localparam int CW        = $clog2(COIN_QUEUE_DEPTH + 1);
    localparam int TW        = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    logic [NIN-1:0] raw_s;
    logic [NIN-1:0] ev_s;

    assign raw_s = {raw_bacon, raw_atum, raw_green, raw_dev, raw_coin};

    for (genvar g = 0; g < NIN; g++) begin : g_cond
        logic [SYNC_STAGES-1:0] sync_r;
        logic [7:0]             db_cnt_r;
        logic                   deb_r;
        logic                   toggle_s;

        // Synchroniser chain; the oldest sample sits in the top bit.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                sync_r <= '0;
            end else begin
                sync_r <= {sync_r[SYNC_STAGES-2:0], raw_s[g]};
            end
        end

        assign toggle_s = (sync_r[SYNC_STAGES-1] != deb_r) &&
                          (db_cnt_r == 8'(DEBOUNCE_CYCLES - 1));
        // The event fires combinationally so the queue sees it on the toggle edge.
        assign ev_s[g]  = toggle_s & sync_r[SYNC_STAGES-1];

        // Debounce: count consecutive samples that disagree with the held level.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                deb_r    <= 1'b0;
                db_cnt_r <= 8'd0;
            end else if (sync_r[SYNC_STAGES-1] == deb_r) begin
                db_cnt_r <= 8'd0;
            end else if (toggle_s) begin
                deb_r    <= sync_r[SYNC_STAGES-1];
                db_cnt_r <= 8'd0;
            end else begin
                db_cnt_r <= db_cnt_r + 8'd1;
            end
        end
    end

    state_t         state_r, state_s;
    logic [TW-1:0]  tmr_r, tmr_s;
    logic [CW-1:0]  coin_cnt_r, coin_cnt_s;
    logic           pend_dev_r, pend_dev_s;
    logic [2:0]     pend_sand_r, pend_sand_s;   // {bacon, atum, green}
    logic           issue_coin_s, issue_dev_s;
    logic [2:0]     issue_sand_s;
    logic           timeout_s, reject_s, any_pend_s;
    logic           m100_r, dev_r, coin_reject_r, timeout_err_r;
    logic [2:0]     sand_r;

    // Issue FSM: choose one request by priority coin > dev > sandwiches.
    always_comb begin
        state_s      = state_r;
        tmr_s        = tmr_r;
        issue_coin_s = 1'b0;
        issue_dev_s  = 1'b0;
        issue_sand_s = 3'b000;
        timeout_s    = 1'b0;
        any_pend_s   = (coin_cnt_r != '0) || pend_dev_r || (pend_sand_r != 3'b000);
        case (state_r)
            IDLE: begin
                if (!busy && any_pend_s) begin
                    state_s = ISSUE;
                    if (coin_cnt_r != '0) begin
                        issue_coin_s = 1'b1;
                    end else if (pend_dev_r) begin
                        issue_dev_s = 1'b1;
                    end else begin
                        issue_sand_s = pend_sand_r;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                state_s = WAIT_HI;
                tmr_s   = '0;
            end
            WAIT_HI: begin
                if (busy) begin
                    state_s = WAIT_LO;
                end else if (tmr_r == TW'(BUSY_TIMEOUT - 1)) begin
                    timeout_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    tmr_s = tmr_r + TW'(1);
                end
            end
            WAIT_LO: begin
                if (!busy) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_LO;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Coin queue and button latches; a simultaneous event and issue leaves the count as is.
    always_comb begin
        coin_cnt_s = coin_cnt_r;
        reject_s   = 1'b0;
        if (ev_s[IDX_COIN] && !issue_coin_s) begin
            if (coin_cnt_r == CW'(COIN_QUEUE_DEPTH)) begin
                reject_s = 1'b1;
            end else begin
                coin_cnt_s = coin_cnt_r + CW'(1);
            end
        end else if (!ev_s[IDX_COIN] && issue_coin_s) begin
            coin_cnt_s = coin_cnt_r - CW'(1);
        end else begin
            coin_cnt_s = coin_cnt_r;
        end
        pend_dev_s = (pend_dev_r & ~issue_dev_s) | ev_s[IDX_DEV];
        if (ev_s[IDX_DEV]) begin
            pend_sand_s = 3'b000;
        end else begin
            pend_sand_s = (pend_sand_r & ~issue_sand_s) | ev_s[4:2];
        end
    end

    // State, queue and registered request outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            tmr_r         <= '0;
            coin_cnt_r    <= '0;
            pend_dev_r    <= 1'b0;
            pend_sand_r   <= 3'b000;
            m100_r        <= 1'b0;
            dev_r         <= 1'b0;
            sand_r        <= 3'b000;
            coin_reject_r <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            tmr_r         <= tmr_s;
            coin_cnt_r    <= coin_cnt_s;
            pend_dev_r    <= pend_dev_s;
            pend_sand_r   <= pend_sand_s;
            m100_r        <= issue_coin_s;
            dev_r         <= issue_dev_s;
            sand_r        <= issue_sand_s;
            coin_reject_r <= reject_s;
            timeout_err_r <= timeout_err_r | timeout_s;
        end
    end

    assign m100        = m100_r;
    assign dev         = dev_r;
    assign r_green     = sand_r[0];
    assign r_atum      = sand_r[1];
    assign r_bacon     = sand_r[2];
    assign coin_reject = coin_reject_r;
    assign timeout_err = timeout_err_r;

`ifdef SANDUBA_INPUT_STATS_EN
    logic [7:0] acc_r, rej_r;

    // Saturating coin statistics.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_r <= 8'd0;
            rej_r <= 8'd0;
        end else begin
            if (issue_coin_s && (acc_r != 8'hFF)) begin
                acc_r <= acc_r + 8'd1;
            end else begin
                acc_r <= acc_r;
            end
            if (reject_s && (rej_r != 8'hFF)) begin
                rej_r <= rej_r + 8'd1;
            end else begin
                rej_r <= rej_r;
            end
        end
    end

    assign coins_accepted = acc_r;
    assign coins_rejected = rej_r;
`endif

endmodule
